carrd_vissue: RTL and testbench



---
 rtl/carrd_vissue.sv | 184 ++++++++++++++++++
 tb/tb_carrd_vissue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/carrd_vissue.sv
// carrd_vissue: in-order vector issue sequencer for the CARRD coprocessor.
// Buffers pre-decoded vector instructions with their scalar snapshots, tracks
// pending vreg writes in a 32-bit scoreboard, and dispatches the head entry to
// its functional unit when that unit is free and no RAW/WAW hazard exists.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        enqueue handshake (in_ready is registered !full)
//   in_instr, in_xdata       payload carried to the FU
//   in_fu                    target FU; NUM_FU encodes vconfig
//   in_vd/vs1/vs2, flags     register indices and operand-use flags
//   in_span                  LMUL group size (1, 2 or 4; others act as 1)
//   fu_busy, fu_done         per-FU backpressure and completion pulse
//   disp_*                   registered one-cycle dispatch pulse and payload
//   q_count, sb_pending      occupancy and scoreboard
//   idle                     queue empty, scoreboard clear, nothing in flight
module carrd_vissue #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned NUM_FU = 3,
  parameter int unsigned FUW    = $clog2(NUM_FU + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [31:0]               in_xdata,
  input  logic [FUW-1:0]            in_fu,
  input  logic [4:0]                in_vd,
  input  logic [4:0]                in_vs1,
  input  logic [4:0]                in_vs2,
  input  logic                      in_writes_vd,
  input  logic                      in_uses_vs1,
  input  logic                      in_uses_vs2,
  input  logic [2:0]                in_span,
  input  logic [NUM_FU-1:0]         fu_busy,
  input  logic [NUM_FU-1:0]         fu_done,
  output logic                      disp_valid,
  output logic [NUM_FU-1:0]         disp_fu,
  output logic                      disp_vconfig,
  output logic [31:0]               disp_instr,
  output logic [31:0]               disp_xdata,
  output logic [4:0]                disp_vd,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [31:0]               sb_pending,
  output logic                      idle
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    xdata;
    logic [FUW-1:0] fu;
    logic [4:0]     vd;
    logic [4:0]     vs1;
    logic [4:0]     vs2;
    logic           writes_vd;
    logic           uses_vs1;
    logic           uses_vs2;
    logic [2:0]     span;
  } entry_t;

  // Register group bitmap r .. r+span-1, wrapping modulo 32.
  function automatic logic [31:0] grp_mask(input logic [4:0] r, input logic [2:0] span);
    logic [31:0] m;
    m = 32'h0;
    m[r] = 1'b1;
    if (span == 3'd2 || span == 3'd4) m[r + 5'd1] = 1'b1;
    if (span == 3'd4) begin
      m[r + 5'd2] = 1'b1;
      m[r + 5'd3] = 1'b1;
    end
    return m;
  endfunction

  entry_t            r_q [QDEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_sb;
  logic [NUM_FU-1:0] r_inflight;
  logic [31:0]       r_fu_mask [NUM_FU];
  logic              r_in_ready, r_idle;
  logic              r_disp_valid, r_disp_vconfig;
  logic [NUM_FU-1:0] r_disp_fu;
  logic [31:0]       r_disp_instr, r_disp_xdata;
  logic [4:0]        r_disp_vd;

  entry_t            w_in_entry, w_head;
  logic              w_push, w_issue, w_is_vcfg, w_fu_free, w_raw, w_waw;
  logic [NUM_FU-1:0] w_fu_oh, w_done, w_inflight_nxt;
  logic [31:0]       w_vd_mask, w_clr, w_set, w_sb_nxt;
  logic [CW-1:0]     w_count_nxt;

  // Issue decision, scoreboard and occupancy next-state.
  always_comb begin
    w_in_entry     = '{in_instr, in_xdata, in_fu, in_vd, in_vs1, in_vs2,
                       in_writes_vd, in_uses_vs1, in_uses_vs2, in_span};
    w_head         = r_q[r_head];
    w_push         = in_valid && r_in_ready && (r_count != CW'(QDEPTH));
    w_is_vcfg      = (w_head.fu >= FUW'(NUM_FU));
    w_vd_mask      = grp_mask(w_head.vd, w_head.span);
    w_raw          = (w_head.uses_vs1 && |(grp_mask(w_head.vs1, w_head.span) & r_sb)) ||
                     (w_head.uses_vs2 && |(grp_mask(w_head.vs2, w_head.span) & r_sb));
    w_waw          = w_head.writes_vd && |(w_vd_mask & r_sb);
    w_fu_free      = 1'b0;
    w_fu_oh        = '0;
    w_done         = fu_done & r_inflight;
    w_clr          = 32'h0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (FUW'(i) == w_head.fu) begin
        w_fu_free  = !fu_busy[i] && !r_inflight[i];
        w_fu_oh[i] = 1'b1;
      end
      if (w_done[i]) w_clr = w_clr | r_fu_mask[i];
    end
    // vconfig waits for a fully drained machine.
    w_issue        = (r_count != '0) &&
                     (w_is_vcfg ? ((r_sb == 32'h0) && (r_inflight == '0))
                                : (w_fu_free && !w_raw && !w_waw));
    w_set          = (w_issue && !w_is_vcfg && w_head.writes_vd) ? w_vd_mask : 32'h0;
    // Dispatch-set bits take precedence over done-clear bits.
    w_sb_nxt       = (r_sb & ~w_clr) | w_set;
    w_inflight_nxt = (r_inflight & ~w_done) |
                     ((w_issue && !w_is_vcfg) ? w_fu_oh : '0);
    w_count_nxt    = r_count + CW'(w_push) - CW'(w_issue);
  end

  // Queue payload storage; pointers and count carry the valid state.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_q[r_tail] <= w_in_entry;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_sb           <= 32'h0;
      r_inflight     <= '0;
      r_in_ready     <= 1'b0;
      r_idle         <= 1'b1;
      r_disp_valid   <= 1'b0;
      r_disp_fu      <= '0;
      r_disp_vconfig <= 1'b0;
      r_disp_instr   <= 32'h0;
      r_disp_xdata   <= 32'h0;
      r_disp_vd      <= 5'h0;
      for (int i = 0; i < int'(NUM_FU); i++) r_fu_mask[i] <= 32'h0;
    end else begin
      if (w_push)  r_tail <= r_tail + PW'(1);
      if (w_issue) r_head <= r_head + PW'(1);
      r_count        <= w_count_nxt;
      r_sb           <= w_sb_nxt;
      r_inflight     <= w_inflight_nxt;
      r_in_ready     <= (w_count_nxt != CW'(QDEPTH));
      r_idle         <= (w_count_nxt == '0) && (w_sb_nxt == 32'h0) && (w_inflight_nxt == '0);
      r_disp_valid   <= w_issue;
      r_disp_fu      <= (w_issue && !w_is_vcfg) ? w_fu_oh : '0;
      r_disp_vconfig <= w_issue && w_is_vcfg;
      r_disp_instr   <= w_issue ? w_head.instr : 32'h0;
      r_disp_xdata   <= w_issue ? w_head.xdata : 32'h0;
      r_disp_vd      <= w_issue ? w_head.vd : 5'h0;
      for (int i = 0; i < int'(NUM_FU); i++) begin
        if (w_done[i]) r_fu_mask[i] <= 32'h0;
        if (w_issue && !w_is_vcfg && w_fu_oh[i])
          r_fu_mask[i] <= w_head.writes_vd ? w_vd_mask : 32'h0;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign idle         = r_idle;
  assign q_count      = r_count;
  assign sb_pending   = r_sb;
  assign disp_valid   = r_disp_valid;
  assign disp_fu      = r_disp_fu;
  assign disp_vconfig = r_disp_vconfig;
  assign disp_instr   = r_disp_instr;
  assign disp_xdata   = r_disp_xdata;
  assign disp_vd      = r_disp_vd;

endmodule

// File: tb/tb_carrd_vissue.sv
// Directed bench for carrd_vissue (QDEPTH=4, NUM_FU=3).
module tb_carrd_vissue;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_xdata;
  logic [1:0]  in_fu;
  logic [4:0]  in_vd, in_vs1, in_vs2;
  logic        in_writes_vd, in_uses_vs1, in_uses_vs2;
  logic [2:0]  in_span;
  logic [2:0]  fu_busy, fu_done;
  logic        disp_valid, disp_vconfig, idle;
  logic [2:0]  disp_fu;
  logic [31:0] disp_instr, disp_xdata, sb_pending;
  logic [4:0]  disp_vd;
  logic [2:0]  q_count;

  int checks   = 0;
  int failures = 0;

  carrd_vissue #(.QDEPTH(4), .NUM_FU(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_xdata(in_xdata), .in_fu(in_fu),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_writes_vd(in_writes_vd), .in_uses_vs1(in_uses_vs1), .in_uses_vs2(in_uses_vs2),
    .in_span(in_span), .fu_busy(fu_busy), .fu_done(fu_done),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_vconfig(disp_vconfig),
    .disp_instr(disp_instr), .disp_xdata(disp_xdata), .disp_vd(disp_vd),
    .q_count(q_count), .sb_pending(sb_pending), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one instruction for one clock edge, then withdraw it.
  task automatic offer(input logic [1:0] fu, input logic [4:0] vd, input logic [4:0] vs1,
                       input logic [4:0] vs2, input logic wr, input logic u1, input logic u2,
                       input logic [2:0] span, input logic [31:0] instr);
    in_fu = fu; in_vd = vd; in_vs1 = vs1; in_vs2 = vs2;
    in_writes_vd = wr; in_uses_vs1 = u1; in_uses_vs2 = u2; in_span = span;
    in_instr = instr; in_xdata = ~instr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic done(input logic [2:0] m);
    fu_done = m;
    tick();
    fu_done = 3'b000;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_xdata = '0; in_fu = '0;
    in_vd = '0; in_vs1 = '0; in_vs2 = '0; in_writes_vd = 1'b0; in_uses_vs1 = 1'b0;
    in_uses_vs2 = 1'b0; in_span = 3'd1; fu_busy = '0; fu_done = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_sb", sb_pending, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Basic ALU op: fu0, vd=3.
    offer(2'd0, 5'd3, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_A001);
    chk("alu_qcount", q_count, 1);
    chk("alu_no_disp_yet", disp_valid, 0);
    tick();
    chk("alu_disp_valid", disp_valid, 1);
    chk("alu_disp_fu", disp_fu, 3'b001);
    chk("alu_disp_instr", disp_instr, 32'h0000_A001);
    chk("alu_disp_xdata", disp_xdata, 32'hFFFF_5FFE);
    chk("alu_disp_vd", disp_vd, 3);
    chk("alu_sb", sb_pending, 32'h0000_0008);
    chk("alu_idle", idle, 0);
    done(3'b001);
    chk("alu_disp_pulse", disp_valid, 0);
    chk("alu_sb_clear", sb_pending, 0);
    chk("alu_idle_after", idle, 1);

    // RAW: A writes v4 on fu0, B reads vs2=4 on fu1.
    offer(2'd0, 5'd4, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_B00A);
    offer(2'd1, 5'd5, 5'd0, 5'd4, 1, 0, 1, 3'd1, 32'h0000_B00B);
    chk("raw_a_disp", disp_fu, 3'b001);
    chk("raw_qcount", q_count, 1);
    chk("raw_sb", sb_pending, 32'h0000_0010);
    tick(); tick();
    chk("raw_b_held", disp_valid, 0);
    done(3'b001);
    chk("raw_b_held_done_cycle", disp_valid, 0);
    chk("raw_sb_cleared", sb_pending, 0);
    tick();
    chk("raw_b_disp", disp_valid, 1);
    chk("raw_b_fu", disp_fu, 3'b010);
    chk("raw_b_instr", disp_instr, 32'h0000_B00B);
    chk("raw_b_sb", sb_pending, 32'h0000_0020);
    done(3'b010);
    chk("raw_idle", idle, 1);

    // LMUL wrap: vd=31 span 2 sets bits 31 and 0; reader of v0 stalls.
    offer(2'd2, 5'd31, 5'd0, 5'd0, 1, 0, 0, 3'd2, 32'h0000_C031);
    offer(2'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 3'd1, 32'h0000_C0D0);
    chk("wrap_c_fu", disp_fu, 3'b100);
    chk("wrap_sb", sb_pending, 32'h8000_0001);
    tick();
    chk("wrap_d_held", disp_valid, 0);
    done(3'b100);
    chk("wrap_sb_clear", sb_pending, 0);
    tick();
    chk("wrap_d_disp", disp_fu, 3'b001);
    chk("wrap_d_no_sb", sb_pending, 0);
    done(3'b001);
    chk("wrap_idle", idle, 1);

    // Fill: all FUs busy, offer 5 ops into a 4-deep queue.
    fu_busy = 3'b111;
    for (int k = 0; k < 5; k++) begin
      chk("fill_in_ready", in_ready, (k < 4) ? 1 : 0);
      offer(2'(k % 3), 5'(8 + k), 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_F000 + 32'(k));
      chk("fill_qcount", q_count, (k < 4) ? 32'(k + 1) : 4);
    end
    chk("fill_full_ready", in_ready, 0);
    chk("fill_no_disp", disp_valid, 0);
    fu_busy = 3'b000;
    tick();
    chk("drain0_fu", disp_fu, 3'b001);
    chk("drain0_vd", disp_vd, 8);
    chk("drain0_ready", in_ready, 1);
    tick();
    chk("drain1_fu", disp_fu, 3'b010);
    chk("drain1_vd", disp_vd, 9);
    tick();
    chk("drain2_fu", disp_fu, 3'b100);
    chk("drain2_vd", disp_vd, 10);
    chk("drain_sb", sb_pending, 32'h0000_0700);
    tick();
    chk("drain3_held", disp_valid, 0);
    chk("drain3_qcount", q_count, 1);
    done(3'b111);
    tick();
    chk("drain3_fu", disp_fu, 3'b001);
    chk("drain3_vd", disp_vd, 11);
    chk("drain3_qcount_empty", q_count, 0);
    done(3'b001);
    chk("drain_idle", idle, 1);

    // vconfig behind two in-flight ops.
    offer(2'd0, 5'd16, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_0F16);
    offer(2'd1, 5'd17, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_0F17);
    offer(2'd3, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'd1, 32'hC0FF_EE00);
    chk("vcfg_sb", sb_pending, 32'h0003_0000);
    chk("vcfg_qcount", q_count, 1);
    tick();
    chk("vcfg_held0", disp_valid, 0);
    done(3'b001);
    chk("vcfg_sb_half", sb_pending, 32'h0002_0000);
    tick();
    chk("vcfg_held1", disp_valid, 0);
    done(3'b010);
    chk("vcfg_held2", disp_valid, 0);
    tick();
    chk("vcfg_disp", disp_valid, 1);
    chk("vcfg_flag", disp_vconfig, 1);
    chk("vcfg_fu_zero", disp_fu, 0);
    chk("vcfg_instr", disp_instr, 32'hC0FF_EE00);
    chk("vcfg_xdata", disp_xdata, 32'h3F00_11FF);
    chk("vcfg_sb_none", sb_pending, 0);
    chk("vcfg_idle", idle, 1);

    // Reset with 3 queued and 2 in flight.
    offer(2'd0, 5'd20, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_0020);
    offer(2'd1, 5'd21, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_0021);
    offer(2'd2, 5'd22, 5'd20, 5'd0, 1, 1, 0, 3'd1, 32'h0000_0022);
    offer(2'd0, 5'd23, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_0023);
    offer(2'd1, 5'd24, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h0000_0024);
    chk("prerst_qcount", q_count, 3);
    chk("prerst_sb", sb_pending, 32'h0030_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_qcount", q_count, 0);
    chk("rst2_sb", sb_pending, 0);
    chk("rst2_idle", idle, 1);
    chk("rst2_in_ready", in_ready, 0);
    done(3'b011);
    chk("late_done_sb", sb_pending, 0);
    chk("late_done_idle", idle, 1);
    chk("late_done_no_disp", disp_valid, 0);
    chk("late_done_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
